// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-issue controller and the ALU it drives.
// Holds opcodes, FSM state encoding, instruction field positions and operand-select helper.
// Pure declarations: no logic, no latency, no flow control.
package cpu_pkg;

  localparam int CPU_DATA_W = 4;
  localparam int CPU_NREG   = 4;
  localparam int REG_AW     = 2;
  localparam int INSTR_W    = 12;

  // Instruction field positions
  localparam int OPC_HI = 11;
  localparam int OPC_LO = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 6;
  localparam int RS_HI  = 5;
  localparam int RS_LO  = 4;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;
  localparam int RT_HI  = 1;
  localparam int RT_LO  = 0;

  // Opcodes, shared with the ALU
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;
  localparam logic [3:0] OP_COPY  = 4'h3;
  localparam logic [3:0] OP_NOT   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_NAND  = 4'h8;
  localparam logic [3:0] OP_NOR   = 4'h9;
  localparam logic [3:0] OP_ADD   = 4'hA;
  localparam logic [3:0] OP_SUB   = 4'hB;
  localparam logic [3:0] OP_ADDI  = 4'hC;
  localparam logic [3:0] OP_SUBI  = 4'hD;
  localparam logic [3:0] OP_SLL   = 4'hE;
  localparam logic [3:0] OP_SRL   = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_t;

  // Second ALU operand comes from the immediate unless the opcode is a
  // register-register operation (AND..SUB). Ops that ignore in2 also get imm.
  function automatic logic op_uses_imm(input logic [3:0] op);
    return !((op >= OP_AND) && (op <= OP_SUB));
  endfunction

endpackage

// File: rtl/seq_regfile.sv
// Small register file: two asynchronous read ports, one synchronous write port.
// Read latency 0 (combinational), write visible the cycle after the write edge.
// No backpressure: a write is accepted every cycle we is high.
module seq_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int NREG   = CPU_NREG,
  parameter int AW     = REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];

  // Next contents: hold, except the addressed entry on a write
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage, cleared to zero on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Instruction-issue controller: latches an instruction, drives the ALU for one cycle, writes back.
// Latency: handshake edge -> ISSUE (1) -> WB with done (2) -> ready again (3); io/flags visible after WB.
// Backpressure: instr_ready is high only in IDLE, so at most one instruction per 3 cycles.
module alu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int NREG   = CPU_NREG
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [3:0]         alu_op,
  output logic [DATA_W-1:0]  alu_in1,
  output logic [DATA_W-1:0]  alu_in2,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_ovf,
  input  logic               alu_udf,
  output logic [DATA_W-1:0]  io_out,
  output logic               io_valid,
  output logic               done,
  output logic               ovf_flag,
  output logic               udf_flag
);

  state_t              state_q, state_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [DATA_W-1:0]   io_out_q, io_out_d;
  logic                io_valid_q, io_valid_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;

  logic [3:0]          opc;
  logic [REG_AW-1:0]   rd, rs, rt;
  logic [DATA_W-1:0]   imm;
  logic [DATA_W-1:0]   rs_dat, rt_dat;
  logic                rf_we;

  assign opc = instr_q[OPC_HI:OPC_LO];
  assign rd  = instr_q[RD_HI:RD_LO];
  assign rs  = instr_q[RS_HI:RS_LO];
  assign rt  = instr_q[RT_HI:RT_LO];
  assign imm = instr_q[IMM_HI:IMM_LO];

  seq_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .AW     (REG_AW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rd),
    .wdata   (alu_result),
    .raddr_a (rs),
    .rdata_a (rs_dat),
    .raddr_b (rt),
    .rdata_b (rt_dat)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: fixed three-step sequence once an instruction is taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instr_valid) state_d = ISSUE;
      ISSUE:   state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ALU command only in ISSUE, NOP otherwise so the ALU holds its result
  always_comb begin
    instr_ready = 1'b0;
    done        = 1'b0;
    rf_we       = 1'b0;
    alu_op      = OP_NOP;
    alu_in1     = '0;
    alu_in2     = '0;
    case (state_q)
      IDLE: instr_ready = 1'b1;
      ISSUE: begin
        alu_op  = opc;
        alu_in1 = rs_dat;
        alu_in2 = op_uses_imm(opc) ? imm : rt_dat;
      end
      WB: begin
        done  = 1'b1;
        rf_we = (opc != OP_NOP) && (opc != OP_READ);
      end
      default: ;
    endcase
  end

  // Datapath next values: instruction capture at handshake, IO and flag update in WB
  always_comb begin
    instr_d    = instr_q;
    io_out_d   = io_out_q;
    io_valid_d = 1'b0;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    if ((state_q == IDLE) && instr_valid) begin
      instr_d = instr;
    end
    if (state_q == WB) begin
      if (opc == OP_NOP) begin
        // The ALU holds stale flags across a NOP, so clear them here
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end else begin
        ovf_d = alu_ovf;
        udf_d = alu_udf;
      end
      if (opc == OP_READ) begin
        io_out_d   = alu_result;
        io_valid_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= '0;
      io_out_q   <= '0;
      io_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      io_out_q   <= io_out_d;
      io_valid_q <= io_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign io_out   = io_out_q;
  assign io_valid = io_valid_q;
  assign ovf_flag = ovf_q;
  assign udf_flag = udf_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a behavioural registered ALU attached.
// Directed vector table, hand-written multi-cycle sequences, then randomized instructions.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  alu_op, alu_in1, alu_in2;
  logic [3:0]  alu_result;
  logic        alu_ovf, alu_udf;
  logic [3:0]  io_out;
  logic        io_valid, done, ovf_flag, udf_flag;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.DATA_W(4), .NREG(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_op      (alu_op),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_result  (alu_result),
    .alu_ovf     (alu_ovf),
    .alu_udf     (alu_udf),
    .io_out      (io_out),
    .io_valid    (io_valid),
    .done        (done),
    .ovf_flag    (ovf_flag),
    .udf_flag    (udf_flag)
  );

  // ALU behaviour: {ovf, udf, result}
  function automatic logic [5:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [7:0] sh;
    logic [3:0] r;
    logic o, u;
    r = '0; o = 1'b0; u = 1'b0; s = '0; sh = '0;
    case (op)
      4'h1: r = b;
      4'h2, 4'h3: r = a;
      4'h4: r = ~a;
      4'h5: r = a & b;
      4'h6: r = a | b;
      4'h7: r = a ^ b;
      4'h8: r = ~(a & b);
      4'h9: r = ~(a | b);
      4'hA, 4'hC: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; o = s[4]; end
      4'hB, 4'hD: begin r = a - b; u = (a < b); end
      4'hE: begin sh = {4'b0, a} << b; r = sh[3:0]; end
      4'hF: r = a >> b;
      default: r = '0;
    endcase
    return {o, u, r};
  endfunction

  // Registered ALU: NOP holds result and flags
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result <= '0; alu_ovf <= 1'b0; alu_udf <= 1'b0;
    end else if (alu_op != 4'h0) begin
      {alu_ovf, alu_udf, alu_result} <= alu_fn(alu_op, alu_in1, alu_in2);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Offer one instruction at a falling edge and check the full 3-cycle sequence.
  // Returns at the falling edge of the cycle where the controller is ready again.
  task automatic exec(input logic [11:0] ins, input logic [3:0] e_in1, input logic [3:0] e_in2,
                      input logic e_ovf, input logic e_udf, input logic e_iov, input logic [3:0] e_io);
    instr = ins; instr_valid = 1'b1;
    chk("ready_offer", instr_ready, 1);
    @(negedge clk);
    instr_valid = 1'b0; instr = 12'($urandom);
    chk("issue_ready", instr_ready, 0);
    chk("issue_op",    alu_op, ins[11:8]);
    chk("issue_in1",   alu_in1, e_in1);
    chk("issue_in2",   alu_in2, e_in2);
    chk("issue_done",  done, 0);
    @(negedge clk);
    chk("wb_done",  done, 1);
    chk("wb_op",    alu_op, 0);
    chk("wb_ready", instr_ready, 0);
    @(negedge clk);
    chk("post_done",  done, 0);
    chk("post_ready", instr_ready, 1);
    chk("post_ovf",   ovf_flag, e_ovf);
    chk("post_udf",   udf_flag, e_udf);
    chk("post_iov",   io_valid, e_iov);
    chk("post_io",    io_out, e_io);
  endtask

  typedef struct {
    logic [11:0] ins;
    logic [3:0]  in1, in2;
    logic        ovf, udf, iov;
    logic [3:0]  io;
  } vec_t;

  vec_t vecs[16];

  logic [3:0] m_regs[4];
  logic [3:0] m_io;

  initial begin
    int accepts;
    logic [11:0] ins;
    logic [3:0]  op, in1, in2, r;
    logic        o, u, iov;

    //            ins      in1    in2    ovf   udf   iov   io
    vecs[0]  = '{12'h149, 4'h0, 4'h9, 1'b0, 1'b0, 1'b0, 4'h0}; // WRITE R1,9
    vecs[1]  = '{12'h210, 4'h9, 4'h0, 1'b0, 1'b0, 1'b1, 4'h9}; // READ R1
    vecs[2]  = '{12'h10C, 4'h0, 4'hC, 1'b0, 1'b0, 1'b0, 4'h9}; // WRITE R0,C
    vecs[3]  = '{12'h147, 4'hC, 4'h7, 1'b0, 1'b0, 1'b0, 4'h9}; // WRITE R1,7
    vecs[4]  = '{12'hA81, 4'hC, 4'h7, 1'b1, 1'b0, 1'b0, 4'h9}; // ADD R2,R0,R1 -> 3
    vecs[5]  = '{12'h6E0, 4'h3, 4'hC, 1'b0, 1'b0, 1'b0, 4'h9}; // OR R3,R2,R0 -> F
    vecs[6]  = '{12'h102, 4'hC, 4'h2, 1'b0, 1'b0, 1'b0, 4'h9}; // WRITE R0,2
    vecs[7]  = '{12'hDC5, 4'h2, 4'h5, 1'b0, 1'b1, 1'b0, 4'h9}; // SUBI R3,R0,5 -> D
    vecs[8]  = '{12'h230, 4'hD, 4'h0, 1'b0, 1'b0, 1'b1, 4'hD}; // READ R3
    vecs[9]  = '{12'h200, 4'h2, 4'h0, 1'b0, 1'b0, 1'b1, 4'h2}; // READ R0
    vecs[10] = '{12'h220, 4'h3, 4'h0, 1'b0, 1'b0, 1'b1, 4'h3}; // READ R2
    vecs[11] = '{12'h14F, 4'h2, 4'hF, 1'b0, 1'b0, 1'b0, 4'h3}; // WRITE R1,F
    vecs[12] = '{12'hA91, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 4'h3}; // ADD R2,R1,R1 -> E
    vecs[13] = '{12'h080, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 4'h3}; // NOP (rd=R2)
    vecs[14] = '{12'h220, 4'hE, 4'h0, 1'b0, 1'b0, 1'b1, 4'hE}; // READ R2: NOP wrote nothing
    vecs[15] = '{12'h143, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0, 4'hE}; // WRITE R1,3

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_done",  done, 0);
    chk("rst_iov",   io_valid, 0);
    chk("rst_io",    io_out, 0);
    chk("rst_ovf",   ovf_flag, 0);
    chk("rst_udf",   udf_flag, 0);
    chk("rst_op",    alu_op, 0);
    chk("rst_in1",   alu_in1, 0);
    chk("rst_in2",   alu_in2, 0);

    for (int i = 0; i < 16; i++) begin
      exec(vecs[i].ins, vecs[i].in1, vecs[i].in2, vecs[i].ovf, vecs[i].udf, vecs[i].iov, vecs[i].io);
    end

    // Back-to-back SLL/SRL with instr_valid held high
    accepts = 0;
    instr = 12'hE52; instr_valid = 1'b1;           // SLL R1,R1,2
    for (int c = 0; c < 6; c++) begin
      if (instr_valid && instr_ready) accepts++;
      if (c == 1) begin
        chk("b2b_sll_op",  alu_op, 4'hE);
        chk("b2b_sll_in1", alu_in1, 4'h3);
        chk("b2b_sll_in2", alu_in2, 4'h2);
        instr = 12'hF53;                            // SRL R1,R1,3
      end
      if (c == 2 || c == 5) chk("b2b_done", done, 1);
      if (c == 4) begin
        chk("b2b_srl_op",  alu_op, 4'hF);
        chk("b2b_srl_in1", alu_in1, 4'hC);
        chk("b2b_srl_in2", alu_in2, 4'h3);
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("b2b_accepts", accepts, 2);
    exec(12'h210, 4'h1, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1); // READ R1 -> 1

    // Reset during ISSUE of ADD R2,R0,R1
    instr = 12'hA81; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("mid_issue_op", alu_op, 4'hA);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", instr_ready, 1);
    chk("mid_rst_done",  done, 0);
    chk("mid_rst_op",    alu_op, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("mid_after_done",  done, 0);
      chk("mid_after_ready", instr_ready, 1);
      @(negedge clk);
    end
    exec(12'h220, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0); // READ R2 -> 0

    // Randomized instructions against the reference model
    for (int k = 0; k < 4; k++) m_regs[k] = '0;
    m_io = '0;
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) begin
        instr = 12'($urandom);
        @(negedge clk);
        chk("rnd_idle_done", done, 0);
      end
      ins = 12'($urandom);
      op  = ins[11:8];
      in1 = m_regs[ins[5:4]];
      in2 = (op >= 4'h5 && op <= 4'hB) ? m_regs[ins[1:0]] : ins[3:0];
      {o, u, r} = alu_fn(op, in1, in2);
      iov = 1'b0;
      if (op == 4'h0) begin
        o = 1'b0; u = 1'b0;
      end else if (op == 4'h2) begin
        m_io = r; iov = 1'b1;
      end else begin
        m_regs[ins[7:6]] = r;
      end
      exec(ins, in1, in2, o, u, iov, m_io);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d/%0d", n_pass, n_tot);
    $fatal(1);
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Instruction-issue controller that drives the processor ALU's command side and consumes its registered result. It accepts 12-bit instructions over a valid/ready handshake, reads operands from an internal 4×4-bit register file, presents `alu_op`/`alu_in1`/`alu_in2` for one cycle, and captures `ALU_Result`/`overflow`/`underflow` one cycle later. It then writes the result back to the register file or to the IO port, and pulses `done`.

## Interface
- `DATA_W`, 4, datapath width; must match the ALU.
- `NREG`, 4, register-file depth; register index width is 2.
- `clk` in 1: single clock, shared with the ALU.
- `rst_n` in 1: asynchronous, active-low reset. The top level drives the ALU's active-high `rst` from `~rst_n`.
- `instr` in 12: instruction fields:
  - `[11:8]` opcode
  - `[7:6]` rd
  - `[5:4]` rs
  - `[3:0]` imm; `[1:0]` of this field is rt
- `instr_valid` in 1: instruction offered.
- `instr_ready` out 1: controller can accept an instruction.
- `alu_op` out 4: to ALU `ALU_Op`.
- `alu_in1` out 4: to ALU `in1`.
- `alu_in2` out 4: to ALU `in2`.
- `alu_result` in 4: from ALU `ALU_Result`.
- `alu_ovf` in 1: from ALU `overflow`.
- `alu_udf` in 1: from ALU `underflow`.
- `io_out` out 4: READ result port.
- `io_valid` out 1: one-cycle pulse when `io_out` is updated.
- `done` out 1: one-cycle pulse at write-back.
- `ovf_flag` out 1: overflow status of the last completed instruction.
- `udf_flag` out 1: underflow status of the last completed instruction.

## Operation
- States: IDLE, ISSUE, WB.
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid && instr_ready`, latch `instr` and go to ISSUE.
- ISSUE:
  - Drive `alu_op`=opcode, `alu_in1`=R[rs], `alu_in2` per the operand-select rule.
  - Go to WB unconditionally.
- WB:
  - `alu_result` and flags are now valid.
  - Apply write-back, pulse `done`, update `ovf_flag`/`udf_flag`, return to IDLE.
- Operand select for `alu_in2`:
  - R[rt] for AND, OR, XOR, NAND, NOR, ADD, SUB (0x5–0xB).
  - imm for WRITE, ADDI, SUBI, SLL, SRL (0x1, 0xC–0xF).
  - Don't-care for NOP, READ, COPY, NOT; drive imm.
- Write-back rules:
  - NOP: no register write. Flags are cleared.
  - READ: `io_out`←`alu_result`, `io_valid` pulses. No register write.
  - All other opcodes: R[rd]←`alu_result`.
- `ovf_flag`/`udf_flag`:
  - Loaded with `alu_ovf`/`alu_udf` in WB.
  - Hold their value otherwise; they are not sticky across instructions.
- Outside ISSUE:
  - `alu_op`=NOP (0x0) and `alu_in1`=`alu_in2`=0, so the ALU holds its result.
- Register file:
  - Synchronous write in WB, asynchronous read.
  - Read-during-write is impossible, because reads occur only in ISSUE.
- Reset:
  - State→IDLE.
  - All registers R0–R3=0.
  - `io_out`=0, `io_valid`=0, `done`=0, `ovf_flag`=0, `udf_flag`=0, `alu_op`=0, `alu_in1`=0, `alu_in2`=0.
  - `instr_ready`=1 immediately after reset deasserts.
- Reset mid-instruction: the instruction is discarded, with no write-back and no `done`.

## Timing
- Cycle 0: handshake edge. Cycle 1: ISSUE. Cycle 2: WB, with `done` high. Cycle 3: IDLE, ready again.
- Throughput: one instruction per 3 cycles; `instr_ready` is low in ISSUE and WB.
- `instr` is sampled only at the handshake edge. Later changes, or `instr_valid` held high, have no effect until the next IDLE.
- Back-to-back dependency needs no forwarding: R[rd] is written at the end of WB, before the next ISSUE reads it.
- Arithmetic is 4-bit unsigned and wraps in the ALU; the controller never alters `alu_result`.

## Structure
- Shared package `cpu_pkg` holds:
  - The opcode constants NOP…SRL (0x0–0xF), shared with the ALU.
  - The state enum {IDLE, ISSUE, WB}.
  - Instruction field positions.
  - The `op_uses_imm()` select function.
- Sub-module `seq_regfile`: NREG×DATA_W file with two async read ports, one sync write port, and async active-low reset.

## Test plan
- Reset → `instr_ready`=1 and all outputs 0. WRITE R1,imm 0x9 → `done` in cycle 2, R1=9.
- WRITE R0,0xC; WRITE R1,0x7; ADD R2,R0,R1 → R2=0x3, `ovf_flag`=1. A following OR clears `ovf_flag` to 0.
- SUBI R3,R0(=2),imm 5 → R3=0xD, `udf_flag`=1. READ R3 → `io_out`=0xD with a 1-cycle `io_valid` pulse, and no register changes.
- SLL R1,R1(=0x3),imm 2 → R1=0xC. SRL R1,R1,imm 3 → R1=0x1. Both instructions issued back-to-back with `instr_valid` held high → exactly 2 accepts, 6 cycles.
- `rst_n` asserted during ISSUE of ADD R2 → R2 unchanged (0), no `done`, state IDLE after release.
- NOP issued after an ADD with `ovf_flag`=1 → `alu_op`=0 seen by the ALU, no register write, `done` pulses, `ovf_flag`=0.
